// File: rtl/mop_issue_queue.sv
// rtl/mop_issue_queue.sv - in-order micro-op issue queue with atomic bundle enqueue
module mop_issue_queue #(
  parameter int MAX_MOP_CNT = 6,
  parameter int MOP_W       = 128,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CNT_W-1:0]             in_cnt,
  input  logic [MAX_MOP_CNT*MOP_W-1:0] in_mops,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MOP_W-1:0]             out_mop,
  output logic                         out_eoi,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic                         err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occupancy_q, occupancy_d;
  logic             err_cnt_q, err_cnt_d;
  logic [MOP_W:0]   mem_q [DEPTH];
  logic [MOP_W:0]   mem_d [DEPTH];

  logic             enq;
  logic             deq;
  logic             cnt_ok;
  logic [CNT_W-1:0] wcnt;

  // Admission looks only at registered occupancy, so a same-cycle dequeue never opens the gate.
  assign in_ready  = !flush && ((OCC_W'(DEPTH) - occupancy_q) >= OCC_W'(MAX_MOP_CNT));
  assign out_valid = (occupancy_q != '0);
  assign out_mop   = out_valid ? mem_q[head_q][MOP_W-1:0] : '0;
  assign out_eoi   = out_valid ? mem_q[head_q][MOP_W] : 1'b0;
  assign occupancy = occupancy_q;
  assign err_cnt   = err_cnt_q;

  assign enq    = in_valid && in_ready;
  assign deq    = out_valid && out_ready;
  assign cnt_ok = (in_cnt <= CNT_W'(MAX_MOP_CNT));
  // Malformed or empty bundles complete the handshake but write nothing.
  assign wcnt   = (enq && cnt_ok) ? in_cnt : '0;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    occupancy_d = occupancy_q;
    err_cnt_d   = err_cnt_q | (enq && !cnt_ok);
    for (int e = 0; e < DEPTH; e++) begin
      mem_d[e] = mem_q[e];
    end
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      occupancy_d = '0;
    end else begin
      for (int i = 0; i < MAX_MOP_CNT; i++) begin
        if (i < int'(wcnt)) begin
          mem_d[tail_q + PTR_W'(i)] = {(i == int'(wcnt) - 1), in_mops[i*MOP_W +: MOP_W]};
        end
      end
      tail_d      = tail_q + PTR_W'(wcnt);
      head_d      = head_q + PTR_W'(deq);
      occupancy_d = occupancy_q + OCC_W'(wcnt) - OCC_W'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      occupancy_q <= '0;
      err_cnt_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occupancy_q <= occupancy_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
